// File: rtl/cpu_cmd_arbiter.sv
// rtl/cpu_cmd_arbiter.sv - two-requester round-robin command arbiter in front of top_cpu
// Optional CPU_ARB_TIMEOUT_EN adds a watchdog that answers a stalled command with rsp_timeout.
module cpu_cmd_arbiter #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [6:0]       req_cmd0,
    input  logic [WIDTH-1:0] req_opa0,
    input  logic [WIDTH-1:0] req_opb0,
    input  logic [WIDTH-1:0] req_opc0,
    input  logic [6:0]       req_cmd1,
    input  logic [WIDTH-1:0] req_opa1,
    input  logic [WIDTH-1:0] req_opb1,
    input  logic [WIDTH-1:0] req_opc1,
    output logic [6:0]       cpu_cmd,
    output logic [WIDTH-1:0] cpu_din1,
    output logic [WIDTH-1:0] cpu_din2,
    output logic [WIDTH-1:0] cpu_din3,
    input  logic             cpu_rdy,
    input  logic             cpu_zero,
    input  logic             cpu_error,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic             rsp_zero,
    output logic             rsp_error,
    output logic             rsp_timeout,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 7 + 3 * WIDTH;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("cpu_cmd_arbiter: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        RESP
    } state_t;

    state_t state, state_next;

    logic [EW-1:0] mem [2][DEPTH];
    logic [PW-1:0] wr_ptr [2];
    logic [PW-1:0] rd_ptr [2];
    logic [EW-1:0] wdata [2];
    logic [1:0]    full, empty, push, pop;
    logic [EW-1:0] head;
    logic          grant, grant_id;
    logic          last_grant, last_grant_d;
    logic          cur_id, cur_id_d;

    logic [6:0]       cmd_d;
    logic [WIDTH-1:0] din1_d, din2_d, din3_d;
    logic             rsp_valid_d, rsp_id_d, rsp_zero_d, rsp_error_d;

    assign wdata[0] = {req_cmd0, req_opa0, req_opb0, req_opc0};
    assign wdata[1] = {req_cmd1, req_opa1, req_opb1, req_opc1};

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    for (genvar i = 0; i < 2; i++) begin : g_flags
        assign empty[i] = (wr_ptr[i] == rd_ptr[i]);
        assign full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                          (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
    end

    assign req_ready = ~full;
    assign push      = req_valid & ~full;
    assign pop       = {grant & grant_id, grant & ~grant_id};
    assign busy      = (state != IDLE);

    // On a tie the requester that was not served last wins.
    assign grant_id = (!empty[0] && !empty[1]) ? ~last_grant : empty[0];
    assign head     = mem[grant_id][rd_ptr[grant_id][AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i][AW-1:0]] <= wdata[i];
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
            end
        end
    end

`ifdef CPU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt, cnt_d;
    logic          rsp_timeout_d;
`endif

    always_comb begin
        state_next   = state;
        grant        = 1'b0;
        cmd_d        = cpu_cmd;
        din1_d       = cpu_din1;
        din2_d       = cpu_din2;
        din3_d       = cpu_din3;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = 1'b0;
        rsp_zero_d   = 1'b0;
        rsp_error_d  = 1'b0;
        cur_id_d     = cur_id;
        last_grant_d = last_grant;
`ifdef CPU_ARB_TIMEOUT_EN
        cnt_d         = cnt;
        rsp_timeout_d = 1'b0;
`endif
        case (state)
            IDLE: begin
                cmd_d  = '0;
                din1_d = '0;
                din2_d = '0;
                din3_d = '0;
                if (cpu_rdy && (empty != 2'b11)) begin
                    grant      = 1'b1;
                    state_next = ISSUE;
                    {cmd_d, din1_d, din2_d, din3_d} = head;
                    cur_id_d   = grant_id;
`ifdef CPU_ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            ISSUE: state_next = WAIT_LOW;
            WAIT_LOW: begin
                if (!cpu_rdy) begin
                    state_next = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (cpu_rdy) begin
                    state_next  = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cur_id;
                    rsp_zero_d  = cpu_zero;
                    rsp_error_d = cpu_error;
                    cmd_d       = '0;
                    din1_d      = '0;
                    din2_d      = '0;
                    din3_d      = '0;
                end
            end
            RESP: begin
                state_next   = IDLE;
                last_grant_d = cur_id;
            end
            default: state_next = IDLE;
        endcase
`ifdef CPU_ARB_TIMEOUT_EN
        if ((state == WAIT_LOW || state == WAIT_HIGH) && state_next != RESP) begin
            if (cnt == CW'(TIMEOUT - 1)) begin
                state_next    = RESP;
                rsp_valid_d   = 1'b1;
                rsp_id_d      = cur_id;
                rsp_timeout_d = 1'b1;
                cmd_d         = '0;
                din1_d        = '0;
                din2_d        = '0;
                din3_d        = '0;
            end else begin
                cnt_d = cnt + CW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_cmd    <= '0;
            cpu_din1   <= '0;
            cpu_din2   <= '0;
            cpu_din3   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_error  <= 1'b0;
            cur_id     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            cpu_cmd    <= cmd_d;
            cpu_din1   <= din1_d;
            cpu_din2   <= din2_d;
            cpu_din3   <= din3_d;
            rsp_valid  <= rsp_valid_d;
            rsp_id     <= rsp_id_d;
            rsp_zero   <= rsp_zero_d;
            rsp_error  <= rsp_error_d;
            cur_id     <= cur_id_d;
            last_grant <= last_grant_d;
        end
    end

`ifdef CPU_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            cnt         <= cnt_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule
